bowling_scorer_mp: RTL and testbench

BOWLING_SCORER_MP -- requirements
Module: bowling_scorer_mp

---
 rtl/bowling_pkg.sv | 19 +
 rtl/bowling_frame_tracker.sv | 149 ++++++++++++++
 rtl/bowling_scorer_mp.sv | 161 ++++++++++++++++
 tb/tb_bowling_scorer_mp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bowling_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the bowling scorer.
package bowling_pkg;

   localparam int unsigned MAX_PINS = 10;

   typedef logic [1:0] state_t;
   localparam state_t StIdle = 2'd0;
   localparam state_t StScan = 2'd1;
   localparam state_t StDone = 2'd2;

   function automatic int unsigned rolls_per_game(input int unsigned frames);
      return 2 * frames + 1;
   endfunction

   function automatic int unsigned sel_width(input int unsigned players);
      return (players > 1) ? $clog2(players) : 1;
   endfunction

endpackage

// File: rtl/bowling_frame_tracker.sv
// Tracks turn order, frame and ball position and assigns buffer slots to accepted rolls.
// Legality checking is present only when BOWLING_ROLL_CHECK_EN is defined.
module bowling_frame_tracker
   import bowling_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned NUM_FRAMES  = 10,
   parameter int unsigned PW          = 1,
   parameter int unsigned IDX_W       = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             roll_i,
   input  logic [3:0]       pin_count_i,
   input  logic             busy_i,
   output logic             wr_en_o,
   output logic [PW-1:0]    wr_player_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [PW-1:0]    current_player_o,
   output logic             game_over_o,
   output logic             roll_error_o
);

   localparam int unsigned   FW         = $clog2(NUM_FRAMES);
   localparam logic [FW-1:0] LastFrame  = FW'(NUM_FRAMES - 1);
   localparam logic [PW-1:0] LastPlayer = PW'(NUM_PLAYERS - 1);
   localparam logic [3:0]    Ten        = 4'(MAX_PINS);
   localparam logic [4:0]    TenW       = 5'(MAX_PINS);

   logic [PW-1:0]    player_q, player_d;
   logic [FW-1:0]    frame_q, frame_d;
   logic [1:0]       ball_q, ball_d;
   logic [3:0]       b0_q, b0_d;
   logic [IDX_W-1:0] wr_ptr_q [NUM_PLAYERS];
   logic             game_over_q, game_over_d;
   logic             roll_error_q, roll_error_d;

   logic       last_frame;
   logic       frame_end;
   logic       legal;
   logic       accept;
   logic [4:0] sum01;

   always_comb begin
      last_frame = (frame_q == LastFrame);
      sum01      = {1'b0, b0_q} + {1'b0, pin_count_i};
      frame_end  = 1'b1;
      if (!last_frame) begin
         if (ball_q == 2'd0) frame_end = (pin_count_i == Ten);
      end else begin
         case (ball_q)
            2'd0:    frame_end = 1'b0;
            // A strike or spare in the final frame earns a third ball.
            2'd1:    frame_end = !((b0_q == Ten) || (sum01 == TenW));
            default: frame_end = 1'b1;
         endcase
      end
   end

`ifdef BOWLING_ROLL_CHECK_EN
   logic [3:0] b1_q;
   logic [4:0] sum12;
   logic       sum_ok;

   always_comb begin
      sum12  = {1'b0, b1_q} + {1'b0, pin_count_i};
      sum_ok = 1'b1;
      if (ball_q == 2'd1) begin
         sum_ok = (last_frame && (b0_q == Ten)) || (sum01 <= TenW);
      end else if (ball_q == 2'd2) begin
         // Third ball shares the rack with ball two only after strike + non-strike.
         sum_ok = (b0_q != Ten) || (b1_q == Ten) || (sum12 <= TenW);
      end
      legal = (pin_count_i <= Ten) && sum_ok;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         b1_q <= '0;
      end else if (accept && (ball_q == 2'd1)) begin
         b1_q <= pin_count_i;
      end
   end

   assign roll_error_d = roll_i & ~accept;
`else
   assign legal        = 1'b1;
   assign roll_error_d = 1'b0;
`endif

   assign accept = roll_i && !game_over_q && !busy_i && legal;

   always_comb begin
      player_d    = player_q;
      frame_d     = frame_q;
      ball_d      = ball_q;
      b0_d        = b0_q;
      game_over_d = game_over_q;
      if (accept) begin
         if (ball_q == 2'd0) b0_d = pin_count_i;
         if (frame_end) begin
            ball_d = 2'd0;
            if (player_q == LastPlayer) begin
               player_d = '0;
               if (last_frame) game_over_d = 1'b1;
               else            frame_d     = frame_q + FW'(1);
            end else begin
               player_d = player_q + PW'(1);
            end
         end else begin
            ball_d = ball_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         player_q     <= '0;
         frame_q      <= '0;
         ball_q       <= '0;
         b0_q         <= '0;
         game_over_q  <= 1'b0;
         roll_error_q <= 1'b0;
      end else begin
         player_q     <= player_d;
         frame_q      <= frame_d;
         ball_q       <= ball_d;
         b0_q         <= b0_d;
         game_over_q  <= game_over_d;
         roll_error_q <= roll_error_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PLAYERS; p++) wr_ptr_q[p] <= '0;
      end else if (accept) begin
         wr_ptr_q[player_q] <= wr_ptr_q[player_q] + IDX_W'(1);
      end
   end

   assign wr_en_o          = accept;
   assign wr_player_o      = player_q;
   assign wr_idx_o         = wr_ptr_q[player_q];
   assign current_player_o = player_q;
   assign game_over_o      = game_over_q;
   assign roll_error_o     = roll_error_q;

endmodule

// File: rtl/bowling_scorer_mp.sv
// Multi-player bowling scorer: per-player roll buffers plus a one-frame-per-cycle score scan.
// Define BOWLING_ROLL_CHECK_EN to enable roll legality checking and roll_error reporting.
module bowling_scorer_mp
   import bowling_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS = 2,
   parameter int unsigned NUM_FRAMES  = 10,
   parameter int unsigned SCORE_W     = 9
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              roll,
   input  logic [3:0]                        pin_count,
   input  logic                              calculate_score,
   input  logic [sel_width(NUM_PLAYERS)-1:0] player_sel,
   output logic [SCORE_W-1:0]                score,
   output logic                              score_valid,
   output logic [sel_width(NUM_PLAYERS)-1:0] current_player,
   output logic                              game_over,
   output logic                              roll_error
);

   localparam int unsigned    PW        = sel_width(NUM_PLAYERS);
   localparam int unsigned    RPG       = rolls_per_game(NUM_FRAMES);
   localparam int unsigned    IDX_W     = $clog2(RPG + 1);
   localparam int unsigned    PTR_W     = $clog2(RPG + 3);
   localparam int unsigned    FW        = $clog2(NUM_FRAMES);
   localparam logic [PTR_W:0] RpgL      = (PTR_W + 1)'(RPG);
   localparam logic [FW-1:0]  LastFrame = FW'(NUM_FRAMES - 1);
   localparam logic [3:0]     Ten       = 4'(MAX_PINS);

   state_t             state_q, state_d;
   logic [FW-1:0]      cnt_q, cnt_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [SCORE_W-1:0] acc_q, acc_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               valid_q, valid_d;
   logic [PW-1:0]      sel_q, sel_d;

   logic [3:0] rolls_q [NUM_PLAYERS][RPG];

   logic             wr_en;
   logic [PW-1:0]    wr_player;
   logic [IDX_W-1:0] wr_idx;
   logic             busy;

   logic [PTR_W:0] idx0, idx1, idx2;
   logic [3:0]     r0, r1, r2;
   logic [4:0]     pair_sum;
   logic [5:0]     frame_pts;
   logic [1:0]     ptr_step;

   assign busy = (state_q != StIdle);

   bowling_frame_tracker #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .NUM_FRAMES  (NUM_FRAMES),
      .PW          (PW),
      .IDX_W       (IDX_W)
   ) u_tracker (
      .clk_i            (clock),
      .rst_i            (reset),
      .roll_i           (roll),
      .pin_count_i      (pin_count),
      .busy_i           (busy),
      .wr_en_o          (wr_en),
      .wr_player_o      (wr_player),
      .wr_idx_o         (wr_idx),
      .current_player_o (current_player),
      .game_over_o      (game_over),
      .roll_error_o     (roll_error)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int i = 0; i < RPG; i++) rolls_q[p][i] <= '0;
         end
      end else if (wr_en && (wr_idx < IDX_W'(RPG))) begin
         rolls_q[wr_player][wr_idx] <= pin_count;
      end
   end

   // Entries past the buffer end read as zero so a short game still scores.
   always_comb begin
      idx0      = {1'b0, ptr_q};
      idx1      = idx0 + (PTR_W + 1)'(1);
      idx2      = idx0 + (PTR_W + 1)'(2);
      r0        = (idx0 < RpgL) ? rolls_q[sel_q][idx0[IDX_W-1:0]] : 4'd0;
      r1        = (idx1 < RpgL) ? rolls_q[sel_q][idx1[IDX_W-1:0]] : 4'd0;
      r2        = (idx2 < RpgL) ? rolls_q[sel_q][idx2[IDX_W-1:0]] : 4'd0;
      pair_sum  = {1'b0, r0} + {1'b0, r1};
      frame_pts = {1'b0, pair_sum};
      ptr_step  = 2'd2;
      if (r0 == Ten) begin
         frame_pts = 6'd10 + {2'b0, r1} + {2'b0, r2};
         ptr_step  = 2'd1;
      end else if (pair_sum == 5'(MAX_PINS)) begin
         frame_pts = 6'd10 + {2'b0, r2};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      acc_d   = acc_q;
      score_d = score_q;
      valid_d = valid_q;
      sel_d   = sel_q;
      case (state_q)
         StIdle: begin
            // A roll in the same cycle wins; the scan request is dropped.
            if (calculate_score && !roll) begin
               state_d = StScan;
               cnt_d   = '0;
               ptr_d   = '0;
               acc_d   = '0;
               valid_d = 1'b0;
               sel_d   = player_sel;
            end
         end
         StScan: begin
            acc_d = acc_q + SCORE_W'(frame_pts);
            ptr_d = ptr_q + PTR_W'(ptr_step);
            cnt_d = cnt_q + FW'(1);
            if (cnt_q == LastFrame) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            score_d = acc_q;
            valid_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= '0;
         acc_q   <= '0;
         score_q <= '0;
         valid_q <= 1'b0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         acc_q   <= acc_d;
         score_q <= score_d;
         valid_q <= valid_d;
         sel_q   <= sel_d;
      end
   end

   assign score       = score_q;
   assign score_valid = valid_q;

endmodule

// File: tb/tb_bowling_scorer_mp.sv
// Directed bench for bowling_scorer_mp: one single-player and one two-player instance.
module tb_bowling_scorer_mp;

`ifdef BOWLING_ROLL_CHECK_EN
   localparam bit ChkEn = 1'b1;
`else
   localparam bit ChkEn = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic       roll_s  [2];
   logic [3:0] pins_s  [2];
   logic       calc_s  [2];
   logic       sel_s   [2];
   logic [8:0] score_s [2];
   logic       valid_s [2];
   logic       cur_s   [2];
   logic       over_s  [2];
   logic       err_s   [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   always #5 clock = ~clock;

   bowling_scorer_mp #(
      .NUM_PLAYERS (1),
      .NUM_FRAMES  (10),
      .SCORE_W     (9)
   ) dut_single (
      .clock           (clock),
      .reset           (reset),
      .roll            (roll_s[0]),
      .pin_count       (pins_s[0]),
      .calculate_score (calc_s[0]),
      .player_sel      (sel_s[0]),
      .score           (score_s[0]),
      .score_valid     (valid_s[0]),
      .current_player  (cur_s[0]),
      .game_over       (over_s[0]),
      .roll_error      (err_s[0])
   );

   bowling_scorer_mp #(
      .NUM_PLAYERS (2),
      .NUM_FRAMES  (10),
      .SCORE_W     (9)
   ) dut_pair (
      .clock           (clock),
      .reset           (reset),
      .roll            (roll_s[1]),
      .pin_count       (pins_s[1]),
      .calculate_score (calc_s[1]),
      .player_sel      (sel_s[1]),
      .score           (score_s[1]),
      .score_valid     (valid_s[1]),
      .current_player  (cur_s[1]),
      .game_over       (over_s[1]),
      .roll_error      (err_s[1])
   );

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic do_roll(input int d, input int p);
      @(negedge clock);
      roll_s[d] = 1'b1;
      pins_s[d] = 4'(p);
      @(negedge clock);
      roll_s[d] = 1'b0;
   endtask

   task automatic do_rolls(input int d, input int p, input int n);
      for (int i = 0; i < n; i++) do_roll(d, p);
   endtask

   task automatic start_scan(input int d, input int s);
      @(negedge clock);
      calc_s[d] = 1'b1;
      sel_s[d]  = 1'(s);
      @(negedge clock);
      calc_s[d] = 1'b0;
   endtask

   // Counts negedges after the scan-start edge until score_valid, bounded.
   task automatic wait_valid(input int d, input int start, output int n);
      n = start;
      while (!valid_s[d] && n < 40) begin
         @(negedge clock);
         n++;
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         roll_s[d] = 1'b0;
         pins_s[d] = 4'd0;
         calc_s[d] = 1'b0;
         sel_s[d]  = 1'b0;
      end
      apply_reset();
      #1;
      check_val("rst_score",  score_s[0], 0);
      check_val("rst_valid",  valid_s[0], 0);
      check_val("rst_player", cur_s[1],   0);
      check_val("rst_over",   over_s[1],  0);
      check_val("rst_err",    err_s[0],   0);

      // 8 then nineteen gutters
      do_roll(0, 8);
      do_rolls(0, 0, 19);
      check_val("g8_over", over_s[0], 1);
      do_roll(0, 0);
      check_val("g8_roll_after_over", err_s[0], ChkEn);
      start_scan(0, 0);
      wait_valid(0, 0, cyc);
      check_val("g8_latency", cyc, 11);
      check_val("g8_score", score_s[0], 8);

      // spare 5,5 then 5 and gutters
      apply_reset();
      do_rolls(0, 5, 3);
      do_rolls(0, 0, 17);
      check_val("spare_over", over_s[0], 1);
      start_scan(0, 0);
      wait_valid(0, 0, cyc);
      check_val("spare_latency", cyc, 11);
      check_val("spare_score", score_s[0], 20);

      // strike, 3, 4 then gutters
      apply_reset();
      do_roll(0, 10);
      do_roll(0, 3);
      do_roll(0, 4);
      do_rolls(0, 0, 16);
      check_val("strike_over", over_s[0], 1);
      start_scan(0, 0);
      wait_valid(0, 0, cyc);
      check_val("strike_latency", cyc, 11);
      check_val("strike_score", score_s[0], 24);

      // two-player perfect games
      apply_reset();
      do_roll(1, 10);
      check_val("pair_turn1", cur_s[1], 1);
      do_roll(1, 10);
      check_val("pair_turn0", cur_s[1], 0);
      do_rolls(1, 10, 21);
      check_val("pair_not_over", over_s[1], 0);
      do_roll(1, 10);
      check_val("pair_over", over_s[1], 1);
      start_scan(1, 0);
      wait_valid(1, 0, cyc);
      check_val("pair_score_p0", score_s[1], 300);
      start_scan(1, 1);
      wait_valid(1, 0, cyc);
      check_val("pair_score_p1", score_s[1], 300);

      // illegal rolls: 7 then 5, then 3, then 11
      apply_reset();
      do_roll(0, 7);
      do_roll(0, 5);
      check_val("ill_sum_err", err_s[0], ChkEn);
      do_roll(0, 3);
      check_val("ill_ok_err", err_s[0], 0);
      do_roll(0, 11);
      check_val("ill_pins_err", err_s[0], ChkEn);
      start_scan(0, 0);
      wait_valid(0, 0, cyc);
      check_val("ill_score", score_s[0], ChkEn ? 10 : 26);

      // activity during a scan, then reset mid-scan
      apply_reset();
      do_roll(0, 4);
      start_scan(0, 0);
      roll_s[0] = 1'b1;
      pins_s[0] = 4'd5;
      calc_s[0] = 1'b1;
      @(negedge clock);
      roll_s[0] = 1'b0;
      calc_s[0] = 1'b0;
      check_val("scan_roll_err", err_s[0], ChkEn);
      wait_valid(0, 1, cyc);
      check_val("scan_latency", cyc, 11);
      check_val("scan_score", score_s[0], 4);
      start_scan(0, 0);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      #1;
      check_val("midrst_score", score_s[0], 0);
      check_val("midrst_valid", valid_s[0], 0);
      @(negedge clock);
      reset = 1'b0;
      start_scan(0, 0);
      wait_valid(0, 0, cyc);
      check_val("postrst_latency", cyc, 11);
      check_val("postrst_score", score_s[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
